// File: rtl/uart_status_tx.sv
// Status reporter: snapshots the NCO phase increment and CIC gain on request and
// sends "P<hex phase> G<gain>\r\n" as back-to-back 8N1 frames.
module uart_status_tx #(
  parameter int CLKS_PER_BIT = 694,
  parameter int PHASE_WIDTH  = 64,
  parameter int GAIN_WIDTH   = 2
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   report_req,
  input  logic [PHASE_WIDTH-1:0] phase_increment,
  input  logic [GAIN_WIDTH-1:0]  cic_gain,
  output logic                   busy,
  output logic                   tx_done,
  output logic                   uart_tx_serial,
  output logic [2:0]             state_dbg
);

  localparam int N      = PHASE_WIDTH / 4 + 6;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BYTE_W = $clog2(N);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] HEX_LAST  = BYTE_W'(N - 6);
  localparam logic [BYTE_W-1:0] SPACE_IDX = BYTE_W'(N - 5);
  localparam logic [BYTE_W-1:0] G_IDX     = BYTE_W'(N - 4);
  localparam logic [BYTE_W-1:0] GAIN_IDX  = BYTE_W'(N - 3);
  localparam logic [BYTE_W-1:0] CR_IDX    = BYTE_W'(N - 2);
  localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(N - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]             state_q, state_d;
  logic [BAUD_W-1:0]      baud_q, baud_d;
  logic [2:0]             bit_q, bit_d;
  logic [BYTE_W-1:0]      byte_q, byte_d;
  logic [PHASE_WIDTH-1:0] phase_snap_q, phase_snap_d;
  logic [GAIN_WIDTH-1:0]  gain_snap_q, gain_snap_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [3:0] nib;
  logic [7:0] cur_byte;
  logic       baud_last;

  // The phase snapshot shifts left one nibble per hex byte, so the digit to send is always on top.
  always_comb begin
    nib      = phase_snap_q[PHASE_WIDTH-1 -: 4];
    cur_byte = 8'h0A;
    if (byte_q == '0) begin
      cur_byte = 8'h50;
    end else if (byte_q <= HEX_LAST) begin
      cur_byte = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    end else if (byte_q == SPACE_IDX) begin
      cur_byte = 8'h20;
    end else if (byte_q == G_IDX) begin
      cur_byte = 8'h47;
    end else if (byte_q == GAIN_IDX) begin
      cur_byte = 8'h30 + 8'(gain_snap_q);
    end else if (byte_q == CR_IDX) begin
      cur_byte = 8'h0D;
    end
  end

  assign baud_last = (baud_q == BAUD_LAST);

  always_comb begin
    state_d      = state_q;
    baud_d       = baud_q;
    bit_d        = bit_q;
    byte_d       = byte_q;
    phase_snap_d = phase_snap_q;
    gain_snap_d  = gain_snap_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (report_req) begin
          state_d      = S_START;
          baud_d       = '0;
          bit_d        = 3'd0;
          byte_d       = '0;
          phase_snap_d = phase_increment;
          gain_snap_d  = cic_gain;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        if (baud_last) begin
          baud_d = '0;
          if (byte_q != '0) begin
            phase_snap_d = {phase_snap_q[PHASE_WIDTH-5:0], 4'h0};
          end
          if (byte_q == BYTE_LAST) begin
            byte_d  = '0;
            state_d = S_DONE;
          end else begin
            byte_d  = byte_q + 1'b1;
            state_d = S_START;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q without decode glitches.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);
    done_d = (state_d == S_DONE);
    if (state_d == S_START) begin
      tx_d = 1'b0;
    end else if (state_d == S_DATA) begin
      tx_d = cur_byte[bit_d];
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q      <= S_IDLE;
      baud_q       <= '0;
      bit_q        <= 3'd0;
      byte_q       <= '0;
      phase_snap_q <= '0;
      gain_snap_q  <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      baud_q       <= baud_d;
      bit_q        <= bit_d;
      byte_q       <= byte_d;
      phase_snap_q <= phase_snap_d;
      gain_snap_q  <= gain_snap_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign uart_tx_serial = tx_q;
  assign busy           = busy_q;
  assign tx_done        = done_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// Directed bench for uart_status_tx: a serial monitor decodes the line into rx_q and
// each report is compared byte-for-byte against its hand-written ASCII text.
module tb_uart_status_tx;

  localparam int CPB = 4;
  localparam int LINE_CYC = 22 * 10 * CPB;

  logic        clk;
  logic        arst;
  logic        report_req;
  logic [63:0] phase_increment;
  logic [1:0]  cic_gain;
  logic        busy;
  logic        tx_done;
  logic        uart_tx_serial;
  logic [2:0]  state_dbg;

  int tests;
  int fails;
  int done_cnt;
  int frame_err;
  int rx_abort;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];

  uart_status_tx #(
    .CLKS_PER_BIT(CPB),
    .PHASE_WIDTH (64),
    .GAIN_WIDTH  (2)
  ) dut (
    .clk            (clk),
    .arst           (arst),
    .report_req     (report_req),
    .phase_increment(phase_increment),
    .cic_gain       (cic_gain),
    .busy           (busy),
    .tx_done        (tx_done),
    .uart_tx_serial (uart_tx_serial),
    .state_dbg      (state_dbg)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge arst) rx_abort = 1;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt++;

  // serial monitor: sample each bit at its first falling edge
  initial begin
    logic [7:0] rx_b;
    forever begin
      @(negedge clk);
      if (uart_tx_serial === 1'b0) begin
        rx_abort = 0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          rx_b[i] = uart_tx_serial;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx_serial !== 1'b1) frame_err++;
        if (rx_abort == 0) rx_q.push_back(rx_b);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // driver: one-cycle request; returns on the falling edge after acceptance
  task automatic send_req(input logic [63:0] ph, input logic [1:0] g);
    phase_increment = ph;
    cic_gain        = g;
    report_req      = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (tx_done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_line(input string tag, input string body);
    logic [7:0] got;
    logic [7:0] exp_b;
    exp_q.delete();
    for (int i = 0; i < body.len(); i++) exp_q.push_back(body[i]);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    check({tag, "_len"}, rx_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      exp_b = exp_q.pop_front();
      got   = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
      check($sformatf("%s_b%0d", tag, i), got, exp_b);
    end
  endtask

  initial begin
    int cyc;
    int bad;
    int done_before;
    tests = 0; fails = 0; done_cnt = 0; frame_err = 0; rx_abort = 0;
    arst = 1'b1; report_req = 1'b0; phase_increment = '0; cic_gain = '0;

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_line", uart_tx_serial, 1);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    arst = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_tx_serial !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);
    check("idle_done_cnt", done_cnt, 0);

    // basic report
    send_req(64'h03dafcea68de1281, 2'd2);
    check("basic_busy_rise", busy, 1);
    check("basic_start_bit", uart_tx_serial, 0);
    wait_done(cyc);
    check("basic_latency", cyc, LINE_CYC);
    check("basic_done_busy", busy, 0);
    check("basic_done_line", uart_tx_serial, 1);
    @(negedge clk);
    check("basic_done_pulse", tx_done, 0);
    check_line("basic", "P03DAFCEA68DE1281 G2");

    // snapshot and ignore
    done_before = done_cnt;
    send_req(64'h01aa60f8b8911654, 2'd1);
    repeat (205) @(negedge clk);
    send_req(64'hffff_ffff_ffff_ffff, 2'd3);
    check("snap_busy_held", busy, 1);
    wait_done(cyc);
    check("snap_latency", cyc, LINE_CYC - 206);
    repeat (100) @(negedge clk);
    check("snap_one_done", done_cnt - done_before, 1);
    check("snap_no_repeat", busy, 0);
    check_line("snap", "P01AA60F8B8911654 G1");
    check("snap_rx_empty", rx_q.size(), 0);

    // hex boundaries followed back-to-back by a second report
    send_req(64'h0123456789ABCDEF, 2'd3);
    wait_done(cyc);
    check("hex_latency", cyc, LINE_CYC);
    send_req(64'hFEDCBA9876543210, 2'd2);
    check("b2b_busy", busy, 1);
    check("b2b_start_bit", uart_tx_serial, 0);
    check("b2b_done_low", tx_done, 0);
    check_line("hex", "P0123456789ABCDEF G3");
    wait_done(cyc);
    check("b2b_latency", cyc, LINE_CYC);
    repeat (5) @(negedge clk);
    check_line("b2b", "PFEDCBA9876543210 G2");

    // reset during byte 9
    send_req(64'h1111_2222_3333_4444, 2'd1);
    repeat (375) @(negedge clk);
    check("mid_busy_before", busy, 1);
    #1 arst = 1'b1;
    #1;
    check("mid_rst_line", uart_tx_serial, 1);
    check("mid_rst_busy", busy, 0);
    @(negedge clk);
    arst = 1'b0;
    repeat (60) @(negedge clk);
    check("mid_idle_busy", busy, 0);
    rx_q.delete();
    send_req(64'h0, 2'd0);
    check("mid_restart_busy", busy, 1);
    wait_done(cyc);
    check("mid_restart_latency", cyc, LINE_CYC);
    repeat (5) @(negedge clk);
    check_line("mid", "P0000000000000000 G0");
    check("mid_rx_empty", rx_q.size(), 0);

    check("frame_errors", frame_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
